// File: rtl/exec_sequencer.sv
// Fetch/decode/execute control FSM for a 6502 core subset.
// Ports: clk, rst (async high), run, pc, acc_reg/x_reg/y_reg, mem_rdata in;
//        next_pc, alu_hold_reg, wr_enable, reg_dest, mem_addr, mem_rd,
//        halted, flag_n, flag_z, instr_done, instr_count out.
module exec_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0200,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [15:0]      pc,
   input  logic [7:0]       acc_reg,
   input  logic [7:0]       x_reg,
   input  logic [7:0]       y_reg,
   input  logic [7:0]       mem_rdata,
   output logic [15:0]      next_pc,
   output logic [7:0]       alu_hold_reg,
   output logic             wr_enable,
   output logic [1:0]       reg_dest,
   output logic [15:0]      mem_addr,
   output logic             mem_rd,
   output logic             halted,
   output logic             flag_n,
   output logic             flag_z,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      ST_RESET, ST_FETCH, ST_DECODE,
      ST_OPER_LO, ST_OPER_HI, ST_HALT
   } state_t;

   localparam logic [7:0] OP_TAX = 8'hAA;
   localparam logic [7:0] OP_TAY = 8'hA8;
   localparam logic [7:0] OP_TXA = 8'h8A;
   localparam logic [7:0] OP_TYA = 8'h98;
   localparam logic [7:0] OP_INX = 8'hE8;
   localparam logic [7:0] OP_INY = 8'hC8;
   localparam logic [7:0] OP_DEX = 8'hCA;
   localparam logic [7:0] OP_DEY = 8'h88;
   localparam logic [7:0] OP_NOP = 8'hEA;
   localparam logic [7:0] OP_LDA = 8'hA9;
   localparam logic [7:0] OP_LDX = 8'hA2;
   localparam logic [7:0] OP_LDY = 8'hA0;
   localparam logic [7:0] OP_JMP = 8'h4C;

   localparam logic [1:0] DST_A = 2'b00;
   localparam logic [1:0] DST_X = 2'b01;
   localparam logic [1:0] DST_Y = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ir;
   logic [7:0] lo;
   logic       ir_ld;
   logic       lo_ld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RESET;
         ir          <= 8'h00;
         lo          <= 8'h00;
         flag_n      <= 1'b0;
         flag_z      <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= state_nxt;
         if (ir_ld) ir <= mem_rdata;
         if (lo_ld) lo <= mem_rdata;
         if (wr_enable) begin
            flag_z <= (alu_hold_reg == 8'h00);
            flag_n <= alu_hold_reg[7];
         end
         if (instr_done) instr_count <= instr_count + CNT_ONE;
      end
   end

   always_comb begin
      state_nxt    = state;
      next_pc      = pc;
      mem_addr     = pc;
      mem_rd       = 1'b0;
      wr_enable    = 1'b0;
      alu_hold_reg = 8'h00;
      reg_dest     = DST_A;
      halted       = 1'b0;
      instr_done   = 1'b0;
      ir_ld        = 1'b0;
      lo_ld        = 1'b0;
      unique case (state)
         ST_RESET: begin
            next_pc   = RESET_PC;
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            if (run) begin
               mem_rd    = 1'b1;
               next_pc   = pc + 16'd1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ir_ld = 1'b1;
            // Implied ops retire here; anything unknown parks in HALT.
            case (mem_rdata)
               OP_TAX, OP_TAY, OP_TXA, OP_TYA,
               OP_INX, OP_INY, OP_DEX, OP_DEY: begin
                  wr_enable  = 1'b1;
                  instr_done = 1'b1;
                  state_nxt  = ST_FETCH;
                  case (mem_rdata)
                     OP_TAX: begin reg_dest = DST_X; alu_hold_reg = acc_reg; end
                     OP_TAY: begin reg_dest = DST_Y; alu_hold_reg = acc_reg; end
                     OP_TXA: begin reg_dest = DST_A; alu_hold_reg = x_reg; end
                     OP_TYA: begin reg_dest = DST_A; alu_hold_reg = y_reg; end
                     OP_INX: begin reg_dest = DST_X; alu_hold_reg = x_reg + 8'd1; end
                     OP_INY: begin reg_dest = DST_Y; alu_hold_reg = y_reg + 8'd1; end
                     OP_DEX: begin reg_dest = DST_X; alu_hold_reg = x_reg - 8'd1; end
                     default: begin reg_dest = DST_Y; alu_hold_reg = y_reg - 8'd1; end
                  endcase
               end
               OP_NOP: begin
                  instr_done = 1'b1;
                  state_nxt  = ST_FETCH;
               end
               OP_LDA, OP_LDX, OP_LDY, OP_JMP: begin
                  mem_rd    = 1'b1;
                  next_pc   = pc + 16'd1;
                  state_nxt = ST_OPER_LO;
               end
               default: state_nxt = ST_HALT;
            endcase
         end
         ST_OPER_LO: begin
            case (ir)
               OP_LDA, OP_LDX, OP_LDY: begin
                  wr_enable    = 1'b1;
                  alu_hold_reg = mem_rdata;
                  instr_done   = 1'b1;
                  state_nxt    = ST_FETCH;
                  case (ir)
                     OP_LDX:  reg_dest = DST_X;
                     OP_LDY:  reg_dest = DST_Y;
                     default: reg_dest = DST_A;
                  endcase
               end
               OP_JMP: begin
                  // Operand pc already advanced; fetch high byte at pc.
                  lo_ld     = 1'b1;
                  mem_rd    = 1'b1;
                  state_nxt = ST_OPER_HI;
               end
               default: state_nxt = ST_HALT;
            endcase
         end
         ST_OPER_HI: begin
            next_pc    = {mem_rdata, lo};
            instr_done = 1'b1;
            state_nxt  = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
         end
         default: state_nxt = ST_RESET;
      endcase
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: register-file/memory model, write scoreboard,
// table of single-instruction vectors and hand-written multi-cycle sequences.
module tb_exec_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [15:0] pc_r = 16'h0000;
   logic [7:0]  a_r = 8'h00;
   logic [7:0]  x_r = 8'h00;
   logic [7:0]  y_r = 8'h00;
   logic [7:0]  mem_rdata = 8'h00;
   logic [15:0] next_pc;
   logic [7:0]  alu_hold_reg;
   logic        wr_enable;
   logic [1:0]  reg_dest;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        halted;
   logic        flag_n;
   logic        flag_z;
   logic        instr_done;
   logic [15:0] instr_count;

   logic [7:0]  mem [0:65535];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_a = 8'h00;
   logic [7:0]  pre_x = 8'h00;
   logic [7:0]  pre_y = 8'h00;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [1:0] dest;
      logic [7:0] val;
   } wr_t;
   wr_t sb_q[$];

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  opnd;
      logic [7:0]  a;
      logic [7:0]  x;
      logic [7:0]  y;
      int          cyc;
      bit          wr;
      logic [1:0]  dest;
      logic [7:0]  val;
      bit          n;
      bit          z;
      logic [15:0] pc;
   } vec_t;
   vec_t vt [12];

   exec_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .pc(pc_r),
      .acc_reg(a_r), .x_reg(x_r), .y_reg(y_r),
      .mem_rdata(mem_rdata), .next_pc(next_pc),
      .alu_hold_reg(alu_hold_reg), .wr_enable(wr_enable),
      .reg_dest(reg_dest), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .halted(halted), .flag_n(flag_n), .flag_z(flag_z),
      .instr_done(instr_done), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // Register file and synchronous program memory around the sequencer.
   always @(posedge clk) begin
      pc_r <= next_pc;
      if (mem_rd) mem_rdata <= mem[mem_addr];
      if (pre_en) begin
         a_r <= pre_a;
         x_r <= pre_x;
         y_r <= pre_y;
      end else if (wr_enable) begin
         case (reg_dest)
            2'b00:   a_r <= alu_hold_reg;
            2'b01:   x_r <= alu_hold_reg;
            2'b10:   y_r <= alu_hold_reg;
            default: ;
         endcase
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Scoreboard: every register write must match the next expected one.
   always @(negedge clk) begin
      if (!rst && wr_enable) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: got write dest=%0d data=%h want none",
                     reg_dest, alu_hold_reg);
         end else begin
            wr_t e;
            e = sb_q.pop_front();
            check("sb_dest", {30'd0, reg_dest}, {30'd0, e.dest});
            check("sb_data", {24'd0, alu_hold_reg}, {24'd0, e.val});
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic push(input logic [1:0] d, input logic [7:0] v);
      wr_t e;
      e.dest = d;
      e.val  = v;
      sb_q.push_back(e);
   endtask

   // Leaves the DUT in FETCH with pc=0200 at a falling edge.
   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vt[0]  = '{8'hAA, 8'h00, 8'h80, 8'h00, 8'h00, 2, 1, 2'd1, 8'h80, 1, 0, 16'h0201};
      vt[1]  = '{8'hA8, 8'h00, 8'h00, 8'h11, 8'h22, 2, 1, 2'd2, 8'h00, 0, 1, 16'h0201};
      vt[2]  = '{8'h8A, 8'h00, 8'h00, 8'h7F, 8'h00, 2, 1, 2'd0, 8'h7F, 0, 0, 16'h0201};
      vt[3]  = '{8'h98, 8'h00, 8'h00, 8'h00, 8'hC3, 2, 1, 2'd0, 8'hC3, 1, 0, 16'h0201};
      vt[4]  = '{8'hE8, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 1, 2'd1, 8'h00, 0, 1, 16'h0201};
      vt[5]  = '{8'hC8, 8'h00, 8'h00, 8'h00, 8'h41, 2, 1, 2'd2, 8'h42, 0, 0, 16'h0201};
      vt[6]  = '{8'hCA, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1, 2'd1, 8'hFF, 1, 0, 16'h0201};
      vt[7]  = '{8'h88, 8'h00, 8'h00, 8'h00, 8'h01, 2, 1, 2'd2, 8'h00, 0, 1, 16'h0201};
      vt[8]  = '{8'hEA, 8'h00, 8'h05, 8'h06, 8'h07, 2, 0, 2'd0, 8'h00, 0, 0, 16'h0201};
      vt[9]  = '{8'hA9, 8'h00, 8'h12, 8'h00, 8'h00, 3, 1, 2'd0, 8'h00, 0, 1, 16'h0202};
      vt[10] = '{8'hA2, 8'hFE, 8'h00, 8'h00, 8'h00, 3, 1, 2'd1, 8'hFE, 1, 0, 16'h0202};
      vt[11] = '{8'hA0, 8'h80, 8'h00, 8'h00, 8'h00, 3, 1, 2'd2, 8'h80, 1, 0, 16'h0202};

      // Reset state while rst is held.
      @(negedge clk);
      check("rst_next_pc", {16'd0, next_pc}, 32'h0200);
      check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_wr", {31'd0, wr_enable}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_done", {31'd0, instr_done}, 32'd0);
      check("rst_flags", {30'd0, flag_n, flag_z}, 32'd0);
      check("rst_count", {16'd0, instr_count}, 32'd0);

      // Single-instruction vectors.
      for (int i = 0; i < 12; i++) begin
         clear_mem();
         mem[16'h0200] = vt[i].op;
         mem[16'h0201] = vt[i].opnd;
         do_reset();
         pre_a = vt[i].a;
         pre_x = vt[i].x;
         pre_y = vt[i].y;
         pre_en = 1'b1;
         @(negedge clk);
         pre_en = 1'b0;
         if (vt[i].wr) push(vt[i].dest, vt[i].val);
         run = 1'b1;
         repeat (vt[i].cyc) @(negedge clk);
         run = 1'b0;
         check($sformatf("v%0d_pc", i), {16'd0, pc_r}, {16'd0, vt[i].pc});
         check($sformatf("v%0d_n", i), {31'd0, flag_n}, {31'd0, vt[i].n});
         check($sformatf("v%0d_z", i), {31'd0, flag_z}, {31'd0, vt[i].z});
         check($sformatf("v%0d_cnt", i), {16'd0, instr_count}, 32'd1);
         check($sformatf("v%0d_pend", i), sb_q.size(), 32'd0);
      end

      // Reset dropped into the middle of an immediate load.
      clear_mem();
      mem[16'h0200] = 8'hA2; mem[16'h0201] = 8'h80;
      mem[16'h0202] = 8'hA9; mem[16'h0203] = 8'h55;
      do_reset();
      push(2'd1, 8'h80);
      run = 1'b1;
      repeat (3) @(negedge clk);
      check("mr_cnt1", {16'd0, instr_count}, 32'd1);
      check("mr_n1", {31'd0, flag_n}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      check("mr_next_pc", {16'd0, next_pc}, 32'h0200);
      check("mr_wr", {31'd0, wr_enable}, 32'd0);
      check("mr_flags", {30'd0, flag_n, flag_z}, 32'd0);
      check("mr_cnt0", {16'd0, instr_count}, 32'd0);
      check("mr_pend", sb_q.size(), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;
      check("mr_pc", {16'd0, pc_r}, 32'h0200);
      check("mr_rd0", {31'd0, mem_rd}, 32'd0);
      @(negedge clk);
      check("mr_rd1", {31'd0, mem_rd}, 32'd1);
      check("mr_addr", {16'd0, mem_addr}, 32'h0200);
      run = 1'b0;

      // Short program: LDA #80, TAX, INX.
      clear_mem();
      mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h80;
      mem[16'h0202] = 8'hAA; mem[16'h0203] = 8'hE8;
      do_reset();
      push(2'd0, 8'h80); push(2'd1, 8'h80); push(2'd1, 8'h81);
      run = 1'b1;
      repeat (3) @(negedge clk);
      check("p_n", {31'd0, flag_n}, 32'd1);
      check("p_z", {31'd0, flag_z}, 32'd0);
      repeat (4) @(negedge clk);
      run = 1'b0;
      check("p_cnt", {16'd0, instr_count}, 32'd3);
      check("p_pc", {16'd0, pc_r}, 32'h0204);
      check("p_x", {24'd0, x_r}, 32'h81);
      check("p_pend", sb_q.size(), 32'd0);

      // LDY #00 then DEY.
      clear_mem();
      mem[16'h0200] = 8'hA0; mem[16'h0201] = 8'h00;
      mem[16'h0202] = 8'h88;
      do_reset();
      push(2'd2, 8'h00); push(2'd2, 8'hFF);
      run = 1'b1;
      repeat (3) @(negedge clk);
      check("ly_z", {31'd0, flag_z}, 32'd1);
      check("ly_n", {31'd0, flag_n}, 32'd0);
      repeat (2) @(negedge clk);
      run = 1'b0;
      check("dy_z", {31'd0, flag_z}, 32'd0);
      check("dy_n", {31'd0, flag_n}, 32'd1);
      check("dy_pend", sb_q.size(), 32'd0);

      // JMP $1234.
      clear_mem();
      mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h34;
      mem[16'h0202] = 8'h12; mem[16'h1234] = 8'hEA;
      do_reset();
      run = 1'b1;
      repeat (4) @(negedge clk);
      check("j_pc", {16'd0, pc_r}, 32'h1234);
      check("j_cnt", {16'd0, instr_count}, 32'd1);
      check("j_flags", {30'd0, flag_n, flag_z}, 32'd0);
      check("j_rd", {31'd0, mem_rd}, 32'd1);
      check("j_addr", {16'd0, mem_addr}, 32'h1234);
      run = 1'b0;

      // LDA #80, JMP $FFFF, NOP: flags survive JMP, pc wraps to 0000.
      clear_mem();
      mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h80;
      mem[16'h0202] = 8'h4C; mem[16'h0203] = 8'hFF;
      mem[16'h0204] = 8'hFF; mem[16'hFFFF] = 8'hEA;
      do_reset();
      push(2'd0, 8'h80);
      run = 1'b1;
      repeat (7) @(negedge clk);
      check("w_pc_ffff", {16'd0, pc_r}, 32'hFFFF);
      check("w_n", {31'd0, flag_n}, 32'd1);
      repeat (2) @(negedge clk);
      run = 1'b0;
      check("w_pc_0000", {16'd0, pc_r}, 32'h0000);
      check("w_cnt", {16'd0, instr_count}, 32'd3);
      check("w_flags", {30'd0, flag_n, flag_z}, 32'd2);

      // run=0 holds FETCH.
      clear_mem();
      mem[16'h0200] = 8'hEA;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_pc", k), {16'd0, pc_r}, 32'h0200);
         check($sformatf("hold%0d_rd", k), {31'd0, mem_rd}, 32'd0);
      end
      run = 1'b1;
      #1;
      check("hold_rd1", {31'd0, mem_rd}, 32'd1);
      check("hold_addr", {16'd0, mem_addr}, 32'h0200);
      @(negedge clk);
      run = 1'b0;

      // Illegal opcode.
      clear_mem();
      do_reset();
      run = 1'b1;
      repeat (2) @(negedge clk);
      run = 1'b0;
      check("ill_halted", {31'd0, halted}, 32'd1);
      check("ill_pc", {16'd0, pc_r}, 32'h0201);
      check("ill_cnt", {16'd0, instr_count}, 32'd0);
      repeat (3) @(negedge clk);
      check("ill_pc_hold", {16'd0, pc_r}, 32'h0201);
      check("ill_rd", {31'd0, mem_rd}, 32'd0);
      check("ill_still", {31'd0, halted}, 32'd1);
      rst = 1'b1;
      #1;
      check("ill_rst_clr", {31'd0, halted}, 32'd0);
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
